// File: rtl/aes_key_schedule.sv
// aes_key_schedule: AES-128/192/256 key expansion into a 60-word store, serving round keys up then down.
// Define KEYSCHED_ZEROIZE_EN to wipe the store and ExpandedKey after the last decryption key is served.
module aes_key_schedule #(
  parameter int MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         KeyValid,
  input  logic [255:0] CipherKey,
  input  logic [3:0]   Nk,
  input  logic         NextEnc,
  input  logic         NextDec,
  output logic [3:0]   Nr,
  output logic         KeyReady,
  output logic [127:0] ExpandedKey,
  output logic         Busy
);
  localparam int DEPTH = 4 * (MAX_NK + 7);
`ifdef KEYSCHED_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, EXPAND, SERVE_ENC, SERVE_DEC} state_t;
  state_t state, state_nx;
  logic [31:0] w [DEPTH];
  logic [255:0] key_r;
  logic [3:0] nk_r, nk_in, enc_ptr, dec_ptr, rc_idx, rp;
  logic [5:0] idx, last;
  logic [2:0] phase;
  logic [7:0] rcon;
  logic [31:0] prev, sub_in, sub_out, temp, new_w;
  logic [127:0] rk;
  logic enc_pend, dec_pend, serve_enc, serve_dec, wrap;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (a^254) followed by the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq = a;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  assign nk_in = (Nk == 4'd6 || Nk == 4'd8) ? Nk : 4'd4;
  assign last = {Nr, 2'b11};
  assign Busy = (state == LOAD) || (state == EXPAND);
  assign wrap = {1'b0, phase} == nk_r - 4'd1;
  assign rcon = rc_idx == 4'd9 ? 8'h1b : rc_idx == 4'd10 ? 8'h36 : 8'h01 << (rc_idx - 4'd1);
  assign prev = w[idx - 6'd1];
  assign sub_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
  assign temp = (phase == 3'd0) ? sub_out ^ {rcon, 24'h0} : (nk_r == 4'd8 && phase == 3'd4) ? sub_out : prev;
  assign new_w = w[idx - 6'(nk_r)] ^ temp;
  assign rp = (state == SERVE_DEC) ? dec_ptr : enc_ptr;
  assign rk = {w[{rp, 2'd0}], w[{rp, 2'd1}], w[{rp, 2'd2}], w[{rp, 2'd3}]};
  assign serve_enc = (state == SERVE_ENC) && (NextEnc || enc_pend) && !KeyReady;
  assign serve_dec = (state == SERVE_DEC) && (NextDec || dec_pend) && !KeyReady;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (KeyValid) state_nx = LOAD;
    else
      case (state)
        LOAD:      state_nx = EXPAND;
        EXPAND:    state_nx = (idx == last) ? SERVE_ENC : EXPAND;
        SERVE_ENC: state_nx = (serve_enc && enc_ptr == Nr) ? SERVE_DEC : SERVE_ENC;
        SERVE_DEC: state_nx = (serve_dec && dec_ptr == 4'd0) ? (ZEROIZE ? IDLE : SERVE_ENC) : SERVE_DEC;
        default:   state_nx = state;
      endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) w[k] <= '0;
      key_r <= '0;
      nk_r <= '0;
      Nr <= '0;
      KeyReady <= 1'b0;
      ExpandedKey <= '0;
      enc_ptr <= '0;
      dec_ptr <= '0;
      rc_idx <= '0;
      idx <= '0;
      phase <= '0;
      enc_pend <= 1'b0;
      dec_pend <= 1'b0;
    end else if (KeyValid) begin
      key_r <= CipherKey;
      nk_r <= nk_in;
      Nr <= nk_in + 4'd6;
      KeyReady <= 1'b0;
      enc_ptr <= '0;
      dec_ptr <= '0;
      enc_pend <= 1'b0;
      dec_pend <= 1'b0;
    end else begin
      KeyReady <= serve_enc || serve_dec;
      if (Busy) begin
        enc_pend <= enc_pend || NextEnc;
        dec_pend <= dec_pend || NextDec;
      end
      case (state)
        LOAD: begin
          for (int k = 0; k < 8; k++)
            if (4'(k) < nk_r) w[k] <= key_r[255-32*k -: 32];
          idx <= 6'(nk_r);
          phase <= '0;
          rc_idx <= 4'd1;
        end
        EXPAND: begin
          w[idx] <= new_w;
          idx <= idx + 6'd1;
          phase <= wrap ? 3'd0 : phase + 3'd1;
          rc_idx <= rc_idx + {3'b0, wrap};
        end
        SERVE_ENC: if (serve_enc) begin
          ExpandedKey <= rk;
          enc_ptr <= (enc_ptr == Nr) ? 4'd0 : enc_ptr + 4'd1;
          dec_ptr <= (enc_ptr == Nr) ? Nr : dec_ptr;
          enc_pend <= 1'b0;
          dec_pend <= 1'b0;
        end
        SERVE_DEC: if (serve_dec) begin
          ExpandedKey <= rk;
          dec_ptr <= (dec_ptr == 4'd0) ? 4'd0 : dec_ptr - 4'd1;
          enc_pend <= 1'b0;
          dec_pend <= 1'b0;
        end
        default: if (ZEROIZE) begin
          for (int k = 0; k < DEPTH; k++) w[k] <= '0;
          ExpandedKey <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb_aes_key_schedule: randomized and known-answer checks of aes_key_schedule against a FIPS-197 style model.
module tb_aes_key_schedule;
  logic clk = 1'b0, rst = 1'b0, KeyValid = 1'b0, NextEnc = 1'b0, NextDec = 1'b0;
  logic [255:0] CipherKey = '0;
  logic [3:0] Nk = 4'd4;
  logic [3:0] Nr;
  logic KeyReady, Busy;
  logic [127:0] ExpandedKey;
  int pass_n = 0, total_n = 0;
  logic [7:0] sb [256];
  logic [7:0] rcon_tab [11] = '{8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] mw [60];
  int mnr;
  logic [127:0] got[$];
  bit b2b;
  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule dut (
    .clk(clk), .rst(rst), .KeyValid(KeyValid), .CipherKey(CipherKey), .Nk(Nk),
    .NextEnc(NextEnc), .NextDec(NextDec), .Nr(Nr), .KeyReady(KeyReady),
    .ExpandedKey(ExpandedKey), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // S-box table from the classic generator walk (p steps by x3, q by its inverse)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      sb[p] = x;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  function automatic int norm_nk(input logic [3:0] n);
    return (n == 4'd6 || n == 4'd8) ? int'(n) : 4;
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    mnr = nk + 6;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (mnr + 1); i++) begin
      t = mw[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk], 24'h0};
      else if (nk == 8 && i % 8 == 4) t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] mrk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic pulse_key(input logic [255:0] k, input logic [3:0] n);
    @(negedge clk);
    KeyValid = 1'b1;
    CipherKey = k;
    Nk = n;
    @(negedge clk);
    KeyValid = 1'b0;
  endtask

  task automatic wait_busy(output int cyc, output int strobes);
    cyc = 0;
    strobes = 0;
    while (Busy && cyc < 200) begin
      cyc++;
      if (KeyReady) strobes++;
      @(negedge clk);
    end
  endtask

  // hold the request levels until n strobes are seen or the budget runs out
  task automatic collect(input bit e, input bit d, input int n);
    int cyc;
    bit prev;
    cyc = 0;
    prev = 1'b0;
    got = {};
    b2b = 1'b0;
    NextEnc = e;
    NextDec = d;
    while (got.size() < n && cyc < 6 * n + 20) begin
      @(negedge clk);
      cyc++;
      if (KeyReady) begin
        got.push_back(ExpandedKey);
        if (prev) b2b = 1'b1;
      end
      prev = KeyReady;
    end
    NextEnc = 1'b0;
    NextDec = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_n++; if (KeyReady !== 1'b0) $display("FAIL reset_keyready: got %b want 0", KeyReady); else pass_n++;
    total_n++; if (ExpandedKey !== 128'h0) $display("FAIL reset_key: got %h want 0", ExpandedKey); else pass_n++;
    total_n++; if (Nr !== 4'd0) $display("FAIL reset_nr: got %0d want 0", Nr); else pass_n++;
    total_n++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else pass_n++;
    rst = 1'b1;
    collect(1'b1, 1'b1, 1);
    total_n++; if (got.size() !== 0) $display("FAIL idle_no_strobe: got %0d strobes want 0", got.size()); else pass_n++;
  endtask

  task automatic test_fips128();
    int cyc, st;
    model_expand(KEY128, 4);
    pulse_key(KEY128, 4'd4);
    total_n++; if (Nr !== 4'd10) $display("FAIL aes128_nr: got %0d want 10", Nr); else pass_n++;
    wait_busy(cyc, st);
    total_n++; if (cyc !== 41) $display("FAIL aes128_busy: got %0d cycles want 41", cyc); else pass_n++;
    collect(1'b1, 1'b0, 11);
    total_n++; if (got.size() !== 11) $display("FAIL aes128_enc_count: got %0d want 11", got.size()); else pass_n++;
    total_n++; if (got.size() > 1 && got[1] !== 128'ha0fafe1788542cb123a339392a6c7605) $display("FAIL aes128_r1: got %h want a0fafe1788542cb123a339392a6c7605", got[1]); else pass_n++;
    total_n++; if (got.size() > 10 && got[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL aes128_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got[10]); else pass_n++;
    total_n++; if (b2b) $display("FAIL aes128_enc_spacing: got back-to-back strobes want none"); else pass_n++;
    collect(1'b0, 1'b1, 11);
    total_n++; if (got.size() !== 11) $display("FAIL aes128_dec_count: got %0d want 11", got.size()); else pass_n++;
    for (int j = 0; j < got.size(); j++) begin
      total_n++; if (got[j] !== mrk(10 - j)) $display("FAIL aes128_dec_r%0d: got %h want %h", 10 - j, got[j], mrk(10 - j)); else pass_n++;
    end
    total_n++; if (got.size() > 10 && got[10] !== KEY128[255:128]) $display("FAIL aes128_dec_last: got %h want %h", got[10], KEY128[255:128]); else pass_n++;
    @(negedge clk);
`ifdef KEYSCHED_ZEROIZE_EN
    total_n++; if (ExpandedKey !== 128'h0) $display("FAIL zeroize_key: got %h want 0", ExpandedKey); else pass_n++;
    collect(1'b1, 1'b1, 1);
    total_n++; if (got.size() !== 0) $display("FAIL zeroize_ignore: got %0d strobes want 0", got.size()); else pass_n++;
`else
    total_n++; if (ExpandedKey !== mrk(0)) $display("FAIL hold_key: got %h want %h", ExpandedKey, mrk(0)); else pass_n++;
    collect(1'b1, 1'b0, 1);
    total_n++; if (got.size() !== 1 || got[0] !== mrk(0)) $display("FAIL reuse_r0: got %0d strobes want r0 %h", got.size(), mrk(0)); else pass_n++;
`endif
  endtask

  task automatic test_aes192();
    int cyc, st;
    model_expand(KEY192, 6);
    pulse_key(KEY192, 4'd6);
    total_n++; if (Nr !== 4'd12) $display("FAIL aes192_nr: got %0d want 12", Nr); else pass_n++;
    wait_busy(cyc, st);
    total_n++; if (cyc !== 47) $display("FAIL aes192_busy: got %0d cycles want 47", cyc); else pass_n++;
    collect(1'b1, 1'b0, 13);
    total_n++; if (got.size() !== 13) $display("FAIL aes192_count: got %0d want 13", got.size()); else pass_n++;
    total_n++; if (got.size() > 1 && got[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) $display("FAIL aes192_r1: got %h want 62f8ead2522c6b7bfe0c91f72402f5a5", got[1]); else pass_n++;
    for (int j = 0; j < got.size(); j++) begin
      total_n++; if (got[j] !== mrk(j)) $display("FAIL aes192_r%0d: got %h want %h", j, got[j], mrk(j)); else pass_n++;
    end
  endtask

  task automatic test_aes256();
    int cyc, st;
    model_expand(KEY256, 8);
    pulse_key(KEY256, 4'd8);
    total_n++; if (Nr !== 4'd14) $display("FAIL aes256_nr: got %0d want 14", Nr); else pass_n++;
    wait_busy(cyc, st);
    total_n++; if (cyc !== 53) $display("FAIL aes256_busy: got %0d cycles want 53", cyc); else pass_n++;
    collect(1'b1, 1'b0, 15);
    total_n++; if (got.size() > 2 && got[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) $display("FAIL aes256_r2: got %h want 9ba354118e6925afa51a8b5f2067fcde", got[2]); else pass_n++;
    for (int j = 0; j < got.size(); j++) begin
      total_n++; if (got[j] !== mrk(j)) $display("FAIL aes256_r%0d: got %h want %h", j, got[j], mrk(j)); else pass_n++;
    end
    collect(1'b0, 1'b1, 15);
    total_n++; if (got.size() !== 15) $display("FAIL aes256_dec_count: got %0d want 15", got.size()); else pass_n++;
    for (int j = 0; j < got.size(); j++) begin
      total_n++; if (got[j] !== mrk(14 - j)) $display("FAIL aes256_dec_r%0d: got %h want %h", 14 - j, got[j], mrk(14 - j)); else pass_n++;
    end
  endtask

  task automatic test_random();
    logic [3:0] choices [6] = '{4'd4, 4'd6, 4'd8, 4'd5, 4'd0, 4'd15};
    logic [255:0] k;
    logic [3:0] n;
    int nk, cyc, st;
    for (int it = 0; it < 6; it++) begin
      k = rand_key();
      n = choices[$urandom_range(0, 5)];
      nk = norm_nk(n);
      model_expand(k, nk);
      pulse_key(k, n);
      total_n++; if (Nr !== 4'(mnr)) $display("FAIL rand%0d_nr: got %0d want %0d", it, Nr, mnr); else pass_n++;
      wait_busy(cyc, st);
      total_n++; if (cyc !== 4 * (mnr + 1) - nk + 1) $display("FAIL rand%0d_busy: got %0d want %0d", it, cyc, 4 * (mnr + 1) - nk + 1); else pass_n++;
      collect(1'b1, 1'b0, mnr + 1);
      total_n++; if (got.size() !== mnr + 1) $display("FAIL rand%0d_count: got %0d want %0d", it, got.size(), mnr + 1); else pass_n++;
      for (int j = 0; j < got.size(); j++) begin
        total_n++; if (got[j] !== mrk(j)) $display("FAIL rand%0d_enc_r%0d: got %h want %h", it, j, got[j], mrk(j)); else pass_n++;
      end
      collect(1'b0, 1'b1, mnr + 1);
      for (int j = 0; j < got.size(); j++) begin
        total_n++; if (got[j] !== mrk(mnr - j)) $display("FAIL rand%0d_dec_r%0d: got %h want %h", it, mnr - j, got[j], mrk(mnr - j)); else pass_n++;
      end
    end
  endtask

  task automatic test_abort();
    logic [255:0] ka, kb;
    int cyc, st;
    ka = rand_key();
    kb = rand_key();
    pulse_key(ka, 4'd4);
    wait_busy(cyc, st);
    collect(1'b1, 1'b0, 3);
    NextEnc = 1'b1;
    pulse_key(kb, 4'd4);
    total_n++; if (KeyReady !== 1'b0) $display("FAIL abort_keyready: got %b want 0", KeyReady); else pass_n++;
    total_n++; if (Busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", Busy); else pass_n++;
    wait_busy(cyc, st);
    total_n++; if (st !== 0) $display("FAIL abort_busy_strobes: got %0d want 0", st); else pass_n++;
    total_n++; if (cyc !== 41) $display("FAIL abort_busy_len: got %0d want 41", cyc); else pass_n++;
    model_expand(kb, 4);
    collect(1'b1, 1'b0, 1);
    total_n++; if (got.size() !== 1 || got[0] !== mrk(0)) $display("FAIL abort_new_r0: got %0d strobes want r0 %h", got.size(), mrk(0)); else pass_n++;
  endtask

  task automatic test_reset_mid_expand();
    pulse_key(rand_key(), 4'd8);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total_n++; if (Busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", Busy); else pass_n++;
    total_n++; if (Nr !== 4'd0) $display("FAIL midrst_nr: got %0d want 0", Nr); else pass_n++;
    total_n++; if (ExpandedKey !== 128'h0 || KeyReady !== 1'b0) $display("FAIL midrst_key: got %h/%b want 0/0", ExpandedKey, KeyReady); else pass_n++;
    @(negedge clk);
    rst = 1'b1;
    collect(1'b1, 1'b1, 1);
    total_n++; if (got.size() !== 0) $display("FAIL midrst_no_strobe: got %0d strobes want 0", got.size()); else pass_n++;
  endtask

  task automatic test_both_requests();
    logic [255:0] k;
    k = rand_key();
    model_expand(k, 4);
    @(negedge clk);
    rst = 1'b0;
    NextEnc = 1'b1;
    NextDec = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    pulse_key(k, 4'd4);
    collect(1'b1, 1'b1, 22);
    total_n++; if (got.size() !== 22) $display("FAIL both_count: got %0d want 22", got.size()); else pass_n++;
    total_n++; if (b2b) $display("FAIL both_spacing: got back-to-back strobes want none"); else pass_n++;
    for (int j = 0; j < got.size(); j++) begin
      total_n++; if (got[j] !== mrk(j < 11 ? j : 21 - j)) $display("FAIL both_s%0d: got %h want %h", j, got[j], mrk(j < 11 ? j : 21 - j)); else pass_n++;
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips128();
    test_aes192();
    test_aes256();
    test_random();
    test_abort();
    test_reset_mid_expand();
    test_both_requests();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
